// File: rtl/psk_tx_core.sv
// BPSK/QPSK transmit core: byte FIFO feeding a symbol mapper that phase-offsets a
// sine LUT to produce one offset-binary DAC word per sample tick.
module psk_tx_core #(
  parameter int DATA_WIDTH        = 12,
  parameter int FIFO_DEPTH        = 16,
  parameter int SAMPLE_DIV        = 2,
  parameter int CARRIER_STEPS     = 16,
  parameter int CYCLES_PER_SYMBOL = 1,
  parameter int PREAMBLE_SYMBOLS  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          mode_qpsk,
  output logic [DATA_WIDTH-1:0]         dac_out,
  output logic                          tx_active,
  output logic                          sym_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [1:0]                    dbg_state_o
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int KW      = $clog2(CARRIER_STEPS);
  localparam int CW      = (CYCLES_PER_SYMBOL > 1) ? $clog2(CYCLES_PER_SYMBOL) : 1;
  localparam int DVW     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SYM_MAX = (PREAMBLE_SYMBOLS > 8) ? PREAMBLE_SYMBOLS : 8;
  localparam int SW      = $clog2(SYM_MAX);
  localparam int MID_INT = 2 ** (DATA_WIDTH - 1);
  localparam int AMP_INT = MID_INT - 1;
  localparam logic [DATA_WIDTH-1:0] MID = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // Taylor series on [-pi, pi]; only ever evaluated for elaboration-time constants.
  function automatic real sin_approx(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lut_val(input int k);
    real pi;
    real x;
    real v;
    pi = 3.14159265358979323846;
    x  = 2.0 * pi * real'(k) / real'(CARRIER_STEPS);
    if (x > pi) x = x - 2.0 * pi;
    v = real'(MID_INT) + real'(AMP_INT) * sin_approx(x);
    return DATA_WIDTH'($rtoi(v + 0.5));
  endfunction

  // Gray-coded dibits for QPSK; BPSK uses phase 0 for a one and phase 2 for a zero.
  function automatic logic [1:0] map_q(input logic [7:0] b, input logic [2:0] s,
                                       input logic qpsk);
    logic [7:0] sh;
    logic [1:0] d;
    map_q = 2'd0;
    if (qpsk) begin
      sh = b >> {s[1:0], 1'b0};
      d  = sh[1:0];
      case (d)
        2'b00:   map_q = 2'd0;
        2'b01:   map_q = 2'd1;
        2'b11:   map_q = 2'd2;
        default: map_q = 2'd3;
      endcase
    end else begin
      sh    = b >> s;
      map_q = sh[0] ? 2'd0 : 2'd2;
    end
  endfunction

  logic [DATA_WIDTH-1:0] lut [CARRIER_STEPS];
  for (genvar g = 0; g < CARRIER_STEPS; g++) begin : g_lut
    localparam logic [DATA_WIDTH-1:0] VAL = lut_val(g);
    assign lut[g] = VAL;
  end

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop, full, empty;
  logic [7:0]    head;

  assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = in_valid && !full;
  assign head  = mem_q[rd_q];
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_data;
  end

  logic [DVW-1:0] sdiv_q;
  logic           tick;
  assign tick = (sdiv_q == DVW'(SAMPLE_DIV - 1));

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d, idx;
  logic [CW-1:0]         cyc_q, cyc_d;
  logic [SW-1:0]         sym_q, sym_d;
  logic [1:0]            q_q, q_d;
  logic [7:0]            byte_q, byte_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] dac_q, dac_d;
  logic                  strobe_q, strobe_d;
  logic                  new_sym, last_sample;
  logic [2:0]            last_sym, nxt_idx;

  assign last_sample = (k_q == KW'(CARRIER_STEPS - 1)) && (cyc_q == CW'(CYCLES_PER_SYMBOL - 1));
  assign last_sym    = mode_q ? 3'd3 : 3'd7;
  assign nxt_idx     = sym_q[2:0] + 3'd1;

  // Symbol-boundary decisions are taken on the tick that starts the next symbol,
  // so the MID sample and tx_active falling land on the same tick.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cyc_d    = cyc_q;
    sym_d    = sym_q;
    q_d      = q_q;
    byte_d   = byte_q;
    mode_d   = mode_q;
    dac_d    = dac_q;
    strobe_d = 1'b0;
    pop      = 1'b0;
    new_sym  = 1'b0;
    idx      = '0;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          dac_d = MID;
          if (!empty) begin
            mode_d  = mode_qpsk;
            new_sym = 1'b1;
            sym_d   = '0;
            if (PREAMBLE_SYMBOLS > 0) begin
              state_d = ST_PRE;
              q_d     = 2'd0;
            end else begin
              state_d = ST_DATA;
              pop     = 1'b1;
              byte_d  = head;
              q_d     = map_q(head, 3'd0, mode_qpsk);
            end
          end
        end
        ST_PRE: begin
          if (last_sample) begin
            new_sym = 1'b1;
            if (sym_q == SW'(PREAMBLE_SYMBOLS - 1)) begin
              state_d = ST_DATA;
              sym_d   = '0;
              pop     = 1'b1;
              byte_d  = head;
              q_d     = map_q(head, 3'd0, mode_q);
            end else begin
              sym_d = sym_q + SW'(1);
              q_d   = 2'd0;
            end
          end
        end
        ST_DATA: begin
          if (last_sample) begin
            if (sym_q[2:0] == last_sym) begin
              if (!empty) begin
                new_sym = 1'b1;
                sym_d   = '0;
                pop     = 1'b1;
                byte_d  = head;
                q_d     = map_q(head, 3'd0, mode_q);
              end else begin
                state_d = ST_IDLE;
                dac_d   = MID;
              end
            end else begin
              new_sym = 1'b1;
              sym_d   = sym_q + SW'(1);
              q_d     = map_q(byte_q, nxt_idx, mode_q);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (new_sym) begin
        k_d      = '0;
        cyc_d    = '0;
        strobe_d = 1'b1;
        idx      = KW'(q_d) << (KW - 2);
        dac_d    = lut[idx];
      end else if (state_q != ST_IDLE && !last_sample) begin
        if (k_q == KW'(CARRIER_STEPS - 1)) begin
          k_d   = '0;
          cyc_d = cyc_q + CW'(1);
        end else begin
          k_d = k_q + KW'(1);
        end
        idx   = k_d + (KW'(q_q) << (KW - 2));
        dac_d = lut[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      sdiv_q   <= '0;
      state_q  <= ST_IDLE;
      k_q      <= '0;
      cyc_q    <= '0;
      sym_q    <= '0;
      q_q      <= '0;
      byte_q   <= '0;
      mode_q   <= 1'b0;
      dac_q    <= MID;
      strobe_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q    <= cnt_d;
      sdiv_q   <= tick ? '0 : sdiv_q + DVW'(1);
      state_q  <= state_d;
      k_q      <= k_d;
      cyc_q    <= cyc_d;
      sym_q    <= sym_d;
      q_q      <= q_d;
      byte_q   <= byte_d;
      mode_q   <= mode_d;
      dac_q    <= dac_d;
      strobe_q <= strobe_d;
    end
  end

  assign in_ready    = !full;
  assign dac_out     = dac_q;
  assign tx_active   = (state_q != ST_IDLE);
  assign sym_strobe  = strobe_q;
  assign fifo_level  = cnt_q;
  assign dbg_state_o = state_q;

endmodule
